// File: rtl/tick_period_monitor.sv
// Receive-side checker for the periodic control-loop enable tick.
// Measures rise-to-rise interval, flags early / late (missing) ticks and
// raises a sticky fault after too many consecutive misses.
module tick_period_monitor #(
  parameter int unsigned NOM_PERIOD = 1000001,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned MAX_MISS   = 3,
  parameter int unsigned LOCK_GOOD  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        clr_fault,
  output logic        locked,
  output logic        period_valid,
  output logic [31:0] period_out,
  output logic        early_pulse,
  output logic        late_pulse,
  output logic        fault,
  output logic [7:0]  miss_cnt
);

  localparam logic [31:0] P_MIN       = 32'(NOM_PERIOD - TOL);
  localparam logic [31:0] P_MAX       = 32'(NOM_PERIOD + TOL);
  localparam logic [31:0] TRACK_LAST  = 32'(NOM_PERIOD + TOL - 1);
  localparam logic [31:0] RESYNC_LAST = 32'(NOM_PERIOD - 1);
  localparam logic [7:0]  MISS_LIM    = 8'(MAX_MISS);
  localparam logic [8:0]  LOCK_LIM    = 9'(LOCK_GOOD);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    RESYNC,
    FAULT
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        tick_q;
  logic        rise;
  logic [31:0] cnt;
  logic [31:0] cnt_nxt;
  logic [31:0] period_meas;
  logic        is_good;
  logic        is_early;
  logic        track_to;
  logic        resync_to;
  logic [7:0]  miss_inc;
  logic        miss_hit;
  logic [7:0]  good_run;
  logic [7:0]  good_run_nxt;
  logic [8:0]  run_inc;
  logic [7:0]  run_sat;

  logic        locked_nxt;
  logic        period_valid_nxt;
  logic [31:0] period_out_nxt;
  logic        early_pulse_nxt;
  logic        late_pulse_nxt;
  logic        fault_nxt;
  logic [7:0]  miss_cnt_nxt;

  // Rising-edge detect and shared measurement terms
  always_comb begin
    rise        = tick_in & ~tick_q;
    period_meas = cnt + 32'd1;
    is_early    = (period_meas < P_MIN);
    is_good     = (period_meas >= P_MIN) && (period_meas <= P_MAX);
    track_to    = (cnt == TRACK_LAST);
    resync_to   = (cnt == RESYNC_LAST);
    miss_inc    = (miss_cnt == 8'hFF) ? 8'hFF : miss_cnt + 8'd1;
    miss_hit    = (miss_inc >= MISS_LIM);
    run_inc     = {1'b0, good_run} + 9'd1;
    run_sat     = run_inc[8] ? 8'hFF : run_inc[7:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; a miss that reaches the limit overrides TRACK/RESYNC
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rise) state_nxt = TRACK;
      end
      TRACK: begin
        if (rise) begin
          if (is_early && miss_hit) state_nxt = FAULT;
        end else if (track_to) begin
          state_nxt = miss_hit ? FAULT : RESYNC;
        end
      end
      RESYNC: begin
        if (rise) begin
          state_nxt = TRACK;
        end else if (resync_to && miss_hit) begin
          state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (clr_fault) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the counter, run tracker and all registered outputs
  always_comb begin
    cnt_nxt          = cnt;
    good_run_nxt     = good_run;
    locked_nxt       = locked;
    period_valid_nxt = 1'b0;
    period_out_nxt   = period_out;
    early_pulse_nxt  = 1'b0;
    late_pulse_nxt   = 1'b0;
    fault_nxt        = fault;
    miss_cnt_nxt     = miss_cnt;
    unique case (state)
      IDLE: begin
        if (rise) cnt_nxt = '0;
      end
      TRACK: begin
        cnt_nxt = cnt + 32'd1;
        if (rise) begin
          cnt_nxt          = '0;
          period_valid_nxt = 1'b1;
          period_out_nxt   = period_meas;
          if (is_early) begin
            early_pulse_nxt = 1'b1;
            miss_cnt_nxt    = miss_inc;
            good_run_nxt    = '0;
            locked_nxt      = 1'b0;
            if (miss_hit) fault_nxt = 1'b1;
          end else if (is_good) begin
            miss_cnt_nxt = '0;
            good_run_nxt = run_sat;
            if (run_inc >= LOCK_LIM) locked_nxt = 1'b1;
          end
        end else if (track_to) begin
          cnt_nxt        = '0;
          late_pulse_nxt = 1'b1;
          miss_cnt_nxt   = miss_inc;
          good_run_nxt   = '0;
          locked_nxt     = 1'b0;
          if (miss_hit) fault_nxt = 1'b1;
        end
      end
      RESYNC: begin
        cnt_nxt = cnt + 32'd1;
        if (rise) begin
          cnt_nxt = '0;
        end else if (resync_to) begin
          cnt_nxt        = '0;
          late_pulse_nxt = 1'b1;
          miss_cnt_nxt   = miss_inc;
          if (miss_hit) fault_nxt = 1'b1;
        end
      end
      FAULT: begin
        locked_nxt = 1'b0;
        if (clr_fault) begin
          fault_nxt    = 1'b0;
          miss_cnt_nxt = '0;
          good_run_nxt = '0;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= 1'b0;
      cnt          <= '0;
      good_run     <= '0;
      locked       <= 1'b0;
      period_valid <= 1'b0;
      period_out   <= '0;
      early_pulse  <= 1'b0;
      late_pulse   <= 1'b0;
      fault        <= 1'b0;
      miss_cnt     <= '0;
    end else begin
      tick_q       <= tick_in;
      cnt          <= cnt_nxt;
      good_run     <= good_run_nxt;
      locked       <= locked_nxt;
      period_valid <= period_valid_nxt;
      period_out   <= period_out_nxt;
      early_pulse  <= early_pulse_nxt;
      late_pulse   <= late_pulse_nxt;
      fault        <= fault_nxt;
      miss_cnt     <= miss_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Scoreboard bench for tick_period_monitor: a timestamp-based reference
// model predicts pulses into a queue; a monitor pops and compares them.
module tb_tick_period_monitor;

  localparam int NOM   = 100;
  localparam int TOL   = 5;
  localparam int MMISS = 3;
  localparam int LGOOD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        clr_fault = 1'b0;
  logic        locked;
  logic        period_valid;
  logic [31:0] period_out;
  logic        early_pulse;
  logic        late_pulse;
  logic        fault;
  logic [7:0]  miss_cnt;

  tick_period_monitor #(
    .NOM_PERIOD(NOM),
    .TOL(TOL),
    .MAX_MISS(MMISS),
    .LOCK_GOOD(LGOOD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick_in(tick_in),
    .clr_fault(clr_fault),
    .locked(locked),
    .period_valid(period_valid),
    .period_out(period_out),
    .early_pulse(early_pulse),
    .late_pulse(late_pulse),
    .fault(fault),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pushed = 0;
  int seen = 0;

  typedef struct {
    bit pv;
    bit early;
    bit late;
    int period;
  } ev_t;

  ev_t exp_q[$];

  typedef enum {W_IDLE, W_TRACK, W_RESYNC, W_FAULT} mode_t;
  mode_t mode = W_IDLE;
  int    cyc = 0;
  int    last_ref = 0;
  int    m_miss = 0;
  int    m_run = 0;
  bit    m_locked = 0;
  bit    m_fault = 0;
  bit    prev_tick = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic note_miss();
    m_miss   = (m_miss < 255) ? m_miss + 1 : 255;
    m_run    = 0;
    m_locked = 0;
    if (m_miss >= MMISS) begin
      m_fault = 1;
      mode    = W_FAULT;
    end
  endtask

  // Reference model: periods are differences of absolute cycle stamps
  always @(posedge clk or negedge rst_n) begin
    bit   rise;
    int   p;
    ev_t  e;
    if (!rst_n) begin
      mode = W_IDLE; cyc = 0; last_ref = 0; m_miss = 0; m_run = 0;
      m_locked = 0; m_fault = 0; prev_tick = 0;
      exp_q.delete();
    end else begin
      rise = tick_in && !prev_tick;
      prev_tick = tick_in;
      cyc++;
      e = '{pv: 0, early: 0, late: 0, period: 0};
      case (mode)
        W_IDLE: if (rise) begin last_ref = cyc; mode = W_TRACK; end
        W_TRACK: begin
          if (rise) begin
            p = cyc - last_ref;
            last_ref = cyc;
            e.pv = 1; e.period = p;
            if (p < NOM - TOL) begin
              e.early = 1;
              note_miss();
            end else if (p <= NOM + TOL) begin
              m_miss = 0;
              m_run  = (m_run < 255) ? m_run + 1 : 255;
              if (m_run >= LGOOD) m_locked = 1;
            end
          end else if (cyc - last_ref == NOM + TOL) begin
            e.late = 1; last_ref = cyc; mode = W_RESYNC;
            note_miss();
          end
        end
        W_RESYNC: begin
          if (rise) begin
            last_ref = cyc; mode = W_TRACK;
          end else if (cyc - last_ref == NOM) begin
            e.late = 1; last_ref = cyc;
            note_miss();
          end
        end
        W_FAULT: if (clr_fault) begin
          m_fault = 0; m_miss = 0; m_run = 0; mode = W_IDLE;
        end
        default: mode = W_IDLE;
      endcase
      if (e.pv || e.early || e.late) begin
        exp_q.push_back(e);
        pushed++;
      end
    end
  end

  // Monitor: pops an expected event whenever the DUT pulses, checks levels each cycle
  always @(negedge clk) begin
    ev_t e;
    bit  any;
    any = period_valid | early_pulse | late_pulse;
    if (any) seen++;
    if (any || exp_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, period_valid, early_pulse, late_pulse}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {29'd0, period_valid, early_pulse, late_pulse},
              {29'd0, e.pv, e.early, e.late});
        if (e.pv && period_valid) check("period_out", period_out, e.period);
      end
    end
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    check("fault", {31'd0, fault}, {31'd0, m_fault});
    check("miss_cnt", {24'd0, miss_cnt}, m_miss);
  end

  task automatic run(input int gap, input int hi, input bit clr_on_rise);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #2;
      tick_in   = (i < hi);
      clr_fault = clr_on_rise && (i == 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      tick_in   = 1'b0;
      clr_fault = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #2; clr_fault = 1'b1;
    @(posedge clk); #2; clr_fault = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_pv"}, {31'd0, period_valid}, 32'd0);
    check({tag, "_period"}, period_out, 32'd0);
    check({tag, "_early"}, {31'd0, early_pulse}, 32'd0);
    check({tag, "_late"}, {31'd0, late_pulse}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_miss"}, {24'd0, miss_cnt}, 32'd0);
  endtask

  initial begin
    int gap;
    int hi;
    int r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // nominal lock, then good-at-edge and early periods, then relock
    repeat (4) run(100, 1, 0);
    run(95, 1, 0);
    run(94, 1, 0);
    repeat (3) run(100, 1, 0);
    // ticks stop: late pulses until fault
    idle(400);
    // ticks ignored in fault, then clear and relock
    repeat (2) run(100, 1, 0);
    idle(5);
    pulse_clr();
    repeat (4) run(100, 1, 0);
    // clear outside fault has no effect
    pulse_clr();
    // held-high tick counted once
    repeat (3) run(100, 5, 0);
    // clear coincident with a rise in fault: clear wins, rise dropped
    idle(400);
    run(100, 1, 1);
    repeat (3) run(100, 1, 0);
    // asynchronous reset while faulted
    idle(400);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) run(100, 1, 0);

    // randomized intervals: mostly good, some early, some missing
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      gap = $urandom_range(NOM - TOL, NOM + TOL);
      else if (r < 8) gap = $urandom_range(40, NOM - TOL - 1);
      else            gap = $urandom_range(NOM + TOL + 1, 350);
      hi = $urandom_range(1, 8);
      if (mode == W_FAULT && $urandom_range(0, 2) == 0) pulse_clr();
      run(gap, hi, 0);
    end
    idle(5);

    check("queue_drain", exp_q.size(), 32'd0);
    check("pulse_count", seen, pushed);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
